// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Round-robin sharing of one combinational ALU between two
//            requesters. Registers the winner's operands toward the ALU,
//            captures the result and masked overflow flag, and pulses done
//            back to the winner. Keeps a saturating overflow count.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arb #(
    parameter int W    = 4,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [2*W-1:0]    a_bus,
    input  logic [2*W-1:0]    b_bus,
    input  logic [3:0]        op_bus,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [1:0]        alu_op,
    input  logic [W-1:0]      alu_out,
    input  logic              alu_err,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [W-1:0]      res,
    output logic              err,
    output logic              busy,
    output logic [CNTW-1:0]   err_cnt
);

    // Operation phases: arbitrate, let the ALU settle, return the response.
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic            r_last_gnt;
    logic [W-1:0]    r_alu_a;
    logic [W-1:0]    r_alu_b;
    logic [1:0]      r_alu_op;
    logic [1:0]      r_gnt;
    logic [1:0]      r_done;
    logic [W-1:0]    r_res;
    logic            r_err;
    logic [CNTW-1:0] r_err_cnt;

    logic            w_issue;
    logic            w_win;
    logic [W-1:0]    w_win_a;
    logic [W-1:0]    w_win_b;
    logic [1:0]      w_win_op;
    logic            w_err_masked;
    logic            w_cnt_sat;

    // A new operation starts only from IDLE with at least one request.
    assign w_issue = (r_state == c_IDLE) && (|req);

    // Winner selection: a lone request wins; a tie goes to the requester
    // that was not served last.
    always_comb begin
        w_win = 1'b0;
        if (req == 2'b10) begin
            w_win = 1'b1;
        end else if (req == 2'b11) begin
            w_win = ~r_last_gnt;
        end
    end

    assign w_win_a  = w_win ? a_bus[2*W-1:W] : a_bus[W-1:0];
    assign w_win_b  = w_win ? b_bus[2*W-1:W] : b_bus[W-1:0];
    assign w_win_op = w_win ? op_bus[3:2]    : op_bus[1:0];

    // Overflow only means something for add/sub (opcode MSB clear).
    assign w_err_masked = alu_err & ~r_alu_op[1];
    assign w_cnt_sat    = &r_err_cnt;

    // Phase sequencing: IDLE -> EXEC on a request, then RESP, then IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  r_state <= (|req) ? c_EXEC : c_IDLE;
                c_EXEC:  r_state <= c_RESP;
                c_RESP:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Latch the winner's operands and remember who was served last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_last_gnt <= 1'b1;
        end else if (w_issue) begin
            r_alu_a    <= w_win_a;
            r_alu_b    <= w_win_b;
            r_alu_op   <= w_win_op;
            r_last_gnt <= w_win;
        end
    end

    // Grant is set at issue and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= '0;
        end else if (w_issue) begin
            r_gnt <= w_win ? 2'b10 : 2'b01;
        end else if (r_state == c_RESP) begin
            r_gnt <= '0;
        end
    end

    // Capture the settled ALU result at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
            r_err <= 1'b0;
        end else if (r_state == c_EXEC) begin
            r_res <= alu_out;
            r_err <= w_err_masked;
        end
    end

    // Single-cycle done pulse to the granted requester during RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= '0;
        end else begin
            r_done <= (r_state == c_EXEC) ? r_gnt : 2'b00;
        end
    end

    // Saturating count of captured overflow results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if ((r_state == c_EXEC) && w_err_masked && !w_cnt_sat) begin
            r_err_cnt <= r_err_cnt + c_CNT_ONE;
        end
    end

    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_op  = r_alu_op;
    assign gnt     = r_gnt;
    assign done    = r_done;
    assign res     = r_res;
    assign err     = r_err;
    assign busy    = (r_state != c_IDLE);
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Scoreboard bench for alu_share_arb with a bench-side ALU and a
//            behavioural reference model of arbitration and results.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arb;

    localparam int W      = 4;
    localparam int CNTW   = 2;
    localparam int c_CMAX = (1 << CNTW) - 1;
    localparam int c_SMAX = (1 << (W-1)) - 1;
    localparam int c_SMIN = -(1 << (W-1));

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req   = '0;
    logic [2*W-1:0]  a_bus = '0;
    logic [2*W-1:0]  b_bus = '0;
    logic [3:0]      op_bus = '0;
    logic [W-1:0]    alu_a, alu_b, alu_out, res;
    logic [1:0]      alu_op, gnt, done;
    logic            alu_err, err, busy;
    logic [CNTW-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.W(W), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .op_bus(op_bus), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_err(alu_err), .gnt(gnt), .done(done),
        .res(res), .err(err), .busy(busy), .err_cnt(err_cnt)
    );

    // Bench-side shared ALU; its flag is deliberately noisy on logic ops.
    logic [W:0] w_sum, w_dif;
    assign w_sum = {alu_a[W-1], alu_a} + {alu_b[W-1], alu_b};
    assign w_dif = {alu_a[W-1], alu_a} - {alu_b[W-1], alu_b};
    always_comb begin
        alu_out = '0;
        alu_err = 1'b0;
        case (alu_op)
            2'b00:   begin alu_out = w_sum[W-1:0]; alu_err = w_sum[W] ^ w_sum[W-1]; end
            2'b01:   begin alu_out = w_dif[W-1:0]; alu_err = w_dif[W] ^ w_dif[W-1]; end
            2'b10:   begin alu_out = alu_a & ~alu_b; alu_err = ^alu_a; end
            default: begin alu_out = alu_a ^ alu_b;  alu_err = ~^alu_b; end
        endcase
    end

    typedef struct {
        int           who;
        logic [W-1:0] res;
        logic         err;
        int           cnt;
        int           due;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sval(logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    // ---------------- reference model ----------------
    int           m_phase = 0, m_last = 1, m_cnt = 0, m_cyc = 0, m_pcnt = 0;
    logic [1:0]   m_gnt = '0, m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0, m_pres = '0;
    logic         m_err = 1'b0, m_perr = 1'b0;
    int           mx, my, mr, mw;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_last = 1; m_cnt = 0; m_gnt = '0;
                m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_err = 1'b0;
                sbq.delete();
            end else begin
                m_cyc++;
                if (m_phase == 1) begin
                    m_res = m_pres; m_err = m_perr; m_cnt = m_pcnt; m_phase = 2;
                end else if (m_phase == 2) begin
                    m_gnt = '0; m_phase = 0;
                end else if (req != 2'b00) begin
                    if (req == 2'b01)      mw = 0;
                    else if (req == 2'b10) mw = 1;
                    else                   mw = 1 - m_last;
                    m_last = mw;
                    m_a  = a_bus[W*mw +: W];
                    m_b  = b_bus[W*mw +: W];
                    m_op = op_bus[2*mw +: 2];
                    mx = sval(m_a);
                    my = sval(m_b);
                    case (m_op)
                        2'b00:   begin mr = mx + my; m_perr = (mr > c_SMAX) || (mr < c_SMIN); end
                        2'b01:   begin mr = mx - my; m_perr = (mr > c_SMAX) || (mr < c_SMIN); end
                        2'b10:   begin mr = int'(m_a & ~m_b); m_perr = 1'b0; end
                        default: begin mr = int'(m_a ^ m_b);  m_perr = 1'b0; end
                    endcase
                    m_pres = mr[W-1:0];
                    m_pcnt = (m_perr && m_cnt < c_CMAX) ? m_cnt + 1 : m_cnt;
                    sbq.push_back('{who: mw, res: m_pres, err: m_perr, cnt: m_pcnt, due: m_cyc + 1});
                    m_gnt   = (mw == 1) ? 2'b10 : 2'b01;
                    m_phase = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            chk("gnt", 32'(gnt), 32'(m_gnt));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("res_hold", 32'(res), 32'(m_res));
            chk("err_hold", 32'(err), 32'(m_err));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (done != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("done_spurious", 32'(done), 32'd0);
                end else begin
                    me = sbq.pop_front();
                    chk("done_who", 32'(done), (me.who == 1) ? 32'd2 : 32'd1);
                    chk("done_timing", 32'(m_cyc), 32'(me.due));
                    chk("done_res", 32'(res), 32'(me.res));
                    chk("done_err", 32'(err), 32'(me.err));
                    chk("done_cnt", 32'(err_cnt), 32'(me.cnt));
                end
            end else if (sbq.size() > 0 && sbq[0].due <= m_cyc) begin
                me = sbq.pop_front();
                chk("done_missing", 32'(done), (me.who == 1) ? 32'd2 : 32'd1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic single(int r, logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op,
                          logic [W-1:0] eres, logic eerr, int ecnt);
        @(negedge clk);
        a_bus  = 8'($urandom);
        b_bus  = 8'($urandom);
        op_bus = 4'($urandom);
        a_bus[W*r +: W] = a;
        b_bus[W*r +: W] = b;
        op_bus[2*r +: 2] = op;
        req = (r == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        req = 2'b00;
        chk("single_gnt", 32'(gnt), (r == 1) ? 32'd2 : 32'd1);
        @(negedge clk);
        chk("single_done", 32'(done), (r == 1) ? 32'd2 : 32'd1);
        chk("single_res", 32'(res), 32'(eres));
        chk("single_err", 32'(err), 32'(eerr));
        chk("single_cnt", 32'(err_cnt), 32'(ecnt));
        @(negedge clk);
        chk("single_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_alu_a"}, 32'(alu_a), 32'd0);
        chk({nm, "_alu_b"}, 32'(alu_b), 32'd0);
        chk({nm, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({nm, "_gnt"}, 32'(gnt), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_res"}, 32'(res), 32'd0);
        chk({nm, "_err"}, 32'(err), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    int order[$];
    int sat_seq[5] = '{1, 2, 3, 3, 3};
    logic [1:0] prev_gnt;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Single request from r0
        single(0, 4'd3, 4'd2, 2'b00, 4'd5, 1'b0, 0);

        // Overflow and masking on r1
        single(1, 4'd7, 4'd1, 2'b00, 4'b1000, 1'b1, 1);
        single(1, 4'b0111, 4'b0001, 2'b10, 4'b0110, 1'b0, 1);

        // Contention: both hold for four operations
        @(negedge clk);
        a_bus  = {4'b1010, 4'd5};
        b_bus  = {4'b0110, 4'd3};
        op_bus = {2'b11, 2'b01};
        req    = 2'b11;
        prev_gnt = 2'b00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (prev_gnt == 2'b00 && gnt != 2'b00) order.push_back(gnt[1] ? 1 : 0);
            prev_gnt = gnt;
            if (done == 2'b01) chk("cont_res0", 32'(res), 32'd2);
            if (done == 2'b10) chk("cont_res1", 32'(res), 32'b1100);
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("cont_grants", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++)
            chk("cont_order", 32'(order[i]), 32'(i % 2));

        // Request dropped after one cycle: -8 - 1
        single(1, 4'b1000, 4'd1, 2'b01, 4'b0111, 1'b1, 2);

        // Reset during EXEC
        @(negedge clk);
        a_bus = 8'h21; b_bus = 8'h13; op_bus = 4'b0000;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // First tie after reset goes to r0
        @(negedge clk);
        a_bus = {4'd2, 4'd1}; b_bus = {4'd1, 4'd1}; op_bus = 4'b0000;
        req = 2'b11;
        @(negedge clk);
        req = 2'b00;
        chk("tie_after_reset", 32'(gnt), 32'd1);
        repeat (3) @(negedge clk);

        // Counter saturation with 7+7
        for (int i = 0; i < 5; i++)
            single(0, 4'd7, 4'd7, 2'b00, 4'b1110, 1'b1, sat_seq[i]);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            req    = 2'($urandom_range(0, 3));
            a_bus  = 8'($urandom);
            b_bus  = 8'($urandom);
            op_bus = 4'($urandom);
        end
        @(negedge clk);
        req = 2'b00;
        repeat (5) @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
